// File: rtl/tlut_result_drain_if.sv
`default_nettype none
// ============================================================================
// Module   : tlut_result_drain_if
// Brief    : Bundle of the start/compute handshake, the simd_cell result bus
//            and the valid/ready result stream used by tlut_result_drain.
//            master = the drain block, slave = the host/cell side.
// Revision : 1.0  initial release
// ============================================================================
interface tlut_result_drain_if #(
    parameter int DIM_ROW1  = 3,
    parameter int DIM_COL2  = 3,
    parameter int ACC_WIDTH = 8
);
    localparam int c_N     = DIM_ROW1 * DIM_COL2;
    localparam int c_IDX_W = (c_N > 1) ? $clog2(c_N) : 1;

    logic                       start;
    logic                       cell_enable;
    logic [c_N*ACC_WIDTH-1:0]   acc_in;
    logic                       out_valid;
    logic                       out_ready;
    logic [ACC_WIDTH-1:0]       out_data;
    logic [c_IDX_W-1:0]         out_idx;
    logic                       out_last;
    logic                       busy;
    logic                       done;

    modport master (
        input  start, acc_in, out_ready,
        output cell_enable, out_valid, out_data, out_idx, out_last, busy, done
    );

    modport slave (
        output start, acc_in, out_ready,
        input  cell_enable, out_valid, out_data, out_idx, out_last, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/tlut_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : tlut_result_drain
// Brief    : Consumer end of the simd_cell result interface. On start it
//            enables the cell for LATENCY cycles, snapshots the packed
//            accumulated_mult matrix and streams its elements one per beat
//            over a valid/ready port.
// Options  : TLUT_DRAIN_SKIP_ZERO_EN - when defined, zero elements are not
//            emitted; out_idx still carries the true element index.
// Revision : 1.0  initial release
// ============================================================================
module tlut_result_drain #(
    parameter int DIM_ROW1  = 3,
    parameter int DIM_COL2  = 3,
    parameter int ACC_WIDTH = 8,
    parameter int LATENCY   = 3
) (
    input  wire logic               clk,
    input  wire logic               rst,
    tlut_result_drain_if.master     bus
);
    localparam int c_N     = DIM_ROW1 * DIM_COL2;
    localparam int c_IDX_W = (c_N > 1) ? $clog2(c_N) : 1;
    localparam int c_CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_MAX  = c_IDX_W'(c_N - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_STREAM  = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [c_CNT_W-1:0]         cnt_q,   cnt_d;
    logic [c_IDX_W-1:0]         idx_q,   idx_d;
    logic [c_N*ACC_WIDTH-1:0]   snap_q,  snap_d;
    logic                       done_q,  done_d;

    logic                       w_last_beat;
    logic [ACC_WIDTH-1:0]       w_elem;

    assign w_elem = snap_q[int'(idx_q)*ACC_WIDTH +: ACC_WIDTH];

`ifdef TLUT_DRAIN_SKIP_ZERO_EN
    logic [c_N-1:0]             mask_q,  mask_d;
    logic [c_IDX_W-1:0]         last_q,  last_d;
    logic [c_N-1:0]             w_nz;
    logic [c_IDX_W-1:0]         w_first;
    logic [c_IDX_W-1:0]         w_lastk;
    logic [c_IDX_W-1:0]         w_next;

    // Nonzero mask of the live cell output plus first/last/next-set searches
    always_comb begin
        w_nz    = '0;
        w_first = '0;
        w_lastk = '0;
        w_next  = idx_q;
        for (int k = 0; k < c_N; k++) begin
            w_nz[k] = |bus.acc_in[k*ACC_WIDTH +: ACC_WIDTH];
        end
        for (int k = c_N - 1; k >= 0; k--) begin
            if (w_nz[k]) w_first = c_IDX_W'(k);
        end
        for (int k = 0; k < c_N; k++) begin
            if (w_nz[k]) w_lastk = c_IDX_W'(k);
        end
        // The stream walks the captured mask, never the live input
        for (int k = c_N - 1; k >= 0; k--) begin
            if (mask_q[k] && (k > int'(idx_q))) w_next = c_IDX_W'(k);
        end
    end

    assign w_last_beat = (idx_q == last_q);
`else
    assign w_last_beat = (idx_q == c_IDX_MAX);
`endif

    // State register and datapath registers; reset wins over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            done_q  <= 1'b0;
`ifdef TLUT_DRAIN_SKIP_ZERO_EN
            mask_q  <= '0;
            last_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            done_q  <= done_d;
`ifdef TLUT_DRAIN_SKIP_ZERO_EN
            mask_q  <= mask_d;
            last_q  <= last_d;
`endif
        end
    end

    // Next-state logic: start -> compute countdown -> capture -> stream beats
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        done_d  = 1'b0;
`ifdef TLUT_DRAIN_SKIP_ZERO_EN
        mask_d  = mask_q;
        last_d  = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_COMPUTE;
                    cnt_d   = c_CNT_LOAD;
                end
            end
            S_COMPUTE: begin
                if (cnt_q == '0) begin
                    // Cell output is valid now; this snapshot is the only copy
                    snap_d = bus.acc_in;
`ifdef TLUT_DRAIN_SKIP_ZERO_EN
                    mask_d = w_nz;
                    last_d = w_lastk;
                    if (w_nz == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        idx_d   = '0;
                    end else begin
                        state_d = S_STREAM;
                        idx_d   = w_first;
                    end
`else
                    state_d = S_STREAM;
                    idx_d   = '0;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_STREAM: begin
                if (bus.out_ready) begin
                    if (w_last_beat) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        idx_d   = '0;
                    end else begin
`ifdef TLUT_DRAIN_SKIP_ZERO_EN
                        idx_d = w_next;
`else
                        idx_d = idx_q + 1'b1;
`endif
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.cell_enable = (state_q == S_COMPUTE);
    assign bus.out_valid   = (state_q == S_STREAM);
    // Beat fields are forced to zero outside STREAM so idle outputs stay quiet
    assign bus.out_data    = bus.out_valid ? w_elem : '0;
    assign bus.out_idx     = bus.out_valid ? idx_q  : '0;
    assign bus.out_last    = bus.out_valid & w_last_beat;
    assign bus.done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_tlut_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlut_result_drain
// Brief    : Scoreboard bench for tlut_result_drain. Expected beats are
//            derived from the applied matrix when start is issued; a monitor
//            compares every accepted beat and the done pulse.
// Revision : 1.0  initial release
// ============================================================================
module tb_tlut_result_drain;
    localparam int c_R   = 3;
    localparam int c_C   = 3;
    localparam int c_W   = 8;
    localparam int c_LAT = 3;
    localparam int c_N   = c_R * c_C;
`ifdef TLUT_DRAIN_SKIP_ZERO_EN
    localparam bit c_SKIP = 1'b1;
`else
    localparam bit c_SKIP = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]     idx;
        logic [c_W-1:0] data;
        logic           last;
    } beat_t;

    logic clk;
    logic rst;
    tlut_result_drain_if #(.DIM_ROW1(c_R), .DIM_COL2(c_C), .ACC_WIDTH(c_W)) bus ();

    tlut_result_drain #(
        .DIM_ROW1(c_R), .DIM_COL2(c_C), .ACC_WIDTH(c_W), .LATENCY(c_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    beat_t  exp_q[$];
    int     checks = 0;
    int     errors = 0;
    int     beats_seen = 0;
    int     done_seen = 0;
    int     rmode = 0;
    int     rphase = 0;
    bit     zero_case = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: elements in ascending k, zeros dropped when skipping
    function automatic void push_expected(input logic [c_N*c_W-1:0] acc);
        int hi = -1;
        for (int k = 0; k < c_N; k++)
            if (!c_SKIP || acc[k*c_W +: c_W] != 0) hi = k;
        for (int k = 0; k < c_N; k++) begin
            logic [c_W-1:0] e = acc[k*c_W +: c_W];
            if (!c_SKIP || e != 0) begin
                beat_t b;
                b.idx  = 4'(k);
                b.data = e;
                b.last = (k == hi);
                exp_q.push_back(b);
            end
        end
    endfunction

    task automatic run_start(input logic [c_N*c_W-1:0] acc);
        bus.acc_in = acc;
        push_expected(acc);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < bound);
        chk("done_timeout", 64'(bus.done), 64'd1);
    endtask

    function automatic logic [c_N*c_W-1:0] rand_acc(input int zero_pct);
        logic [c_N*c_W-1:0] a;
        for (int k = 0; k < c_N; k++) begin
            logic [c_W-1:0] e = c_W'($urandom_range(1, 255));
            if (int'($urandom_range(0, 99)) < zero_pct) e = '0;
            a[k*c_W +: c_W] = e;
        end
        return a;
    endfunction

    // Downstream ready generator: always, 1-0-0 pattern, or random
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       bus.out_ready = 1'b1;
                1:       begin bus.out_ready = (rphase % 3 == 0); rphase++; end
                default: bus.out_ready = 1'(($urandom() & 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on each accepted beat, checks stall hold and done
    initial begin
        beat_t held;
        bit    stall_v = 1'b0;
        bit    prev_last = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_v   = 1'b0;
                prev_last = 1'b0;
            end else begin
                if (bus.done) done_seen++;
                if (!zero_case) chk("done_pulse", 64'(bus.done), 64'(prev_last));
                prev_last = 1'b0;
                if (stall_v) begin
                    chk("stall_hold", 64'({bus.out_valid, bus.out_idx, bus.out_data, bus.out_last}),
                        64'({1'b1, held.idx, held.data, held.last}));
                end
                if (bus.out_valid) begin
                    beat_t act;
                    act.idx  = bus.out_idx;
                    act.data = bus.out_data;
                    act.last = bus.out_last;
                    if (bus.out_ready) begin
                        beat_t e;
                        if (exp_q.size() == 0) begin
                            e = '1;
                        end else begin
                            e = exp_q.pop_front();
                        end
                        chk("beat", 64'(act), 64'(e));
                        beats_seen++;
                        prev_last = act.last;
                        stall_v   = 1'b0;
                    end else begin
                        stall_v = 1'b1;
                        held    = act;
                    end
                end else begin
                    stall_v = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [c_N*c_W-1:0] acc;
        int en_cnt, cyc, b0, d0, n;

        rst = 1'b1;
        bus.start = 1'b0;
        bus.acc_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 64'({bus.cell_enable, bus.out_valid, bus.out_data, bus.out_idx,
            bus.out_last, bus.busy, bus.done}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: basic order and latency
        for (int k = 0; k < c_N; k++) acc[k*c_W +: c_W] = c_W'(10 + k);
        rmode = 0;
        run_start(acc);
        en_cnt = 0;
        cyc = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!bus.out_valid) begin
                en_cnt += int'(bus.cell_enable);
                cyc++;
            end
        end while (!bus.out_valid && n < 50);
        chk("enable_cycles", 64'(en_cnt), 64'(c_LAT));
        chk("valid_latency", 64'(cyc), 64'(c_LAT));
        chk("busy_in_stream", 64'(bus.busy), 64'd1);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.done && cyc < 50);
        chk("stream_cycles", 64'(cyc), 64'(c_N));
        @(negedge clk);
        chk("idle_after_done", 64'({bus.busy, bus.out_valid}), 64'd0);
        chk("queue_empty_t1", 64'(exp_q.size()), 64'd0);

        // 2: backpressure 1,0,0 with constant data
        @(posedge clk);
        #1;
        for (int k = 0; k < c_N; k++) acc[k*c_W +: c_W] = 8'd12;
        rphase = 0;
        rmode = 1;
        b0 = beats_seen;
        run_start(acc);
        wait_done(200);
        chk("beats_t2", 64'(beats_seen - b0), 64'(c_N));
        chk("queue_empty_t2", 64'(exp_q.size()), 64'd0);

        // 3: acc_in changes after capture, start during stream ignored
        @(posedge clk);
        #1;
        rmode = 2;
        acc = rand_acc(0);
        b0 = beats_seen;
        d0 = done_seen;
        run_start(acc);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 50);
        bus.acc_in = '1;
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(200);
        repeat (10) @(negedge clk);
        chk("beats_t3", 64'(beats_seen - b0), 64'(c_N));
        chk("dones_t3", 64'(done_seen - d0), 64'd1);
        chk("busy_after_t3", 64'(bus.busy), 64'd0);
        chk("queue_empty_t3", 64'(exp_q.size()), 64'd0);

        // 4: reset after beat idx 3, then a fresh stream
        @(posedge clk);
        #1;
        rmode = 0;
        acc = rand_acc(0);
        b0 = beats_seen;
        run_start(acc);
        n = 0;
        while (beats_seen < b0 + 4 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("reach_beat3", 64'(beats_seen - b0), 64'd4);
        #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("reset_mid_stream", 64'({bus.cell_enable, bus.out_valid, bus.out_data, bus.out_idx,
            bus.out_last, bus.busy, bus.done}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        acc = rand_acc(0);
        b0 = beats_seen;
        run_start(acc);
        wait_done(200);
        chk("beats_t4", 64'(beats_seen - b0), 64'(c_N));
        chk("queue_empty_t4", 64'(exp_q.size()), 64'd0);

        // 5: sparse matrix and all-zero matrix
        @(posedge clk);
        #1;
        acc = '0;
        acc[0*c_W +: c_W] = 8'd7;
        acc[6*c_W +: c_W] = 8'd5;
        b0 = beats_seen;
        run_start(acc);
        wait_done(200);
        chk("beats_sparse", 64'(beats_seen - b0), c_SKIP ? 64'd2 : 64'(c_N));
        chk("queue_empty_sparse", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
        b0 = beats_seen;
`ifdef TLUT_DRAIN_SKIP_ZERO_EN
        zero_case = 1'b1;
        run_start('0);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.done && cyc < 50);
        chk("allzero_done_time", 64'(cyc), 64'(c_LAT));
        @(posedge clk);
        #1 zero_case = 1'b0;
        chk("allzero_beats", 64'(beats_seen - b0), 64'd0);
`else
        run_start('0);
        wait_done(200);
        chk("allzero_beats", 64'(beats_seen - b0), 64'(c_N));
`endif
        chk("queue_empty_zero", 64'(exp_q.size()), 64'd0);

        // 6: random back-to-back runs, start issued on the done cycle
        @(posedge clk);
        #1;
        rmode = 2;
        d0 = done_seen;
        run_start(rand_acc(30));
        for (int r = 0; r < 6; r++) begin
            wait_done(300);
            run_start(rand_acc(30));
        end
        wait_done(300);
        repeat (4) @(negedge clk);
        chk("dones_random", 64'(done_seen - d0), 64'd7);
        chk("queue_empty_random", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
